buffer_pea_xbar: RTL and testbench

// - Parametrised, registered crossbar between BUF1/BUF2 M1 ports and the PE array. Selects one of N_ENG

---
 rtl/pea_pkg.sv | 48 ++++
 rtl/buffer_pea_route.sv | 49 ++++
 rtl/buffer_pea_xbar.sv | 216 +++++++++++++++++++++
 tb/tb_buffer_pea_xbar.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pea_pkg.sv
// Shared types and idle values for the buffer <-> PE-array crossbar.
package pea_pkg;

  localparam int unsigned PEA_N_BUF     = 33;
  localparam int unsigned PEA_N_PE      = 32;
  localparam int unsigned PEA_DATA_W    = 16;
  localparam int unsigned PEA_ADDR_W    = 10;
  localparam int unsigned PEA_N_ENG     = 3;
  localparam int unsigned PEA_DRAIN_CYC = 4;
  localparam int unsigned ENG_IDLE      = 0;

  typedef enum logic [1:0] {
    AZBY = 2'd0,
    AYBZ = 2'd1,
    BYbZ = 2'd2,
    AYaZ = 2'd3
  } route_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } xbar_state_e;

  typedef struct packed {
    logic [PEA_N_BUF-1:0]  r_en;
    logic [PEA_N_BUF-1:0]  w_en;
    logic [PEA_ADDR_W-1:0] r_addr;
    logic [PEA_ADDR_W-1:0] w_addr;
  } buf_ctrl_t;

  typedef struct packed {
    logic [PEA_N_PE-1:0] mac_enable;
    logic                shifting_h;
    logic                shifting_v;
    logic                dense_adder_reset;
  } pea_ctrl_t;

  localparam buf_ctrl_t BUF_CTRL_IDLE = '0;
  localparam pea_ctrl_t PEA_CTRL_IDLE = '{
    mac_enable:        '0,
    shifting_h:        1'b0,
    shifting_v:        1'b0,
    dense_adder_reset: 1'b1
  };
  localparam route_e ROUTE_IDLE = AYBZ;

endpackage

// File: rtl/buffer_pea_route.sv
// Combinational ping-pong lane crossbar between buffer read data, PEA inputs and buffer write data.
module buffer_pea_route
  import pea_pkg::*;
#(
  parameter int unsigned N_BUF      = PEA_N_BUF,
  parameter int unsigned DATA_W     = PEA_DATA_W,
  parameter int unsigned DENSE_LANE = N_BUF - 1
) (
  input  route_e                        route,
  input  logic [N_BUF-1:0][DATA_W-1:0]  rdata1,
  input  logic [N_BUF-1:0][DATA_W-1:0]  rdata2,
  input  logic [N_BUF-1:0][DATA_W-1:0]  pout,
  output logic [N_BUF-1:0][DATA_W-1:0]  in1,
  output logic [N_BUF-1:0][DATA_W-1:0]  in2,
  output logic [N_BUF-1:0][DATA_W-1:0]  wdata
);

  always_comb begin
    in1   = '0;
    in2   = '0;
    wdata = '0;
    for (int unsigned i = 0; i < N_BUF; i++) begin
      unique case (route)
        AYBZ: begin
          in1[i]   = rdata1[i];
          in2[i]   = rdata2[i];
          wdata[i] = pout[i];
        end
        AZBY: begin
          in1[i]   = rdata2[i];
          in2[i]   = rdata1[i];
          wdata[i] = pout[i];
        end
        // Dense modes broadcast one lane to every second-operand input.
        AYaZ: begin
          in1[i]   = rdata1[i];
          in2[i]   = rdata1[DENSE_LANE];
          wdata[i] = pout[DENSE_LANE];
        end
        BYbZ: begin
          in1[i]   = rdata2[i];
          in2[i]   = rdata2[DENSE_LANE];
          wdata[i] = pout[DENSE_LANE];
        end
      endcase
    end
  end

endmodule

// File: rtl/buffer_pea_xbar.sv
// Registered engine-select crossbar: handshake-driven engine/route switching with a drain window.
module buffer_pea_xbar
  import pea_pkg::*;
#(
  parameter int unsigned N_BUF      = PEA_N_BUF,
  parameter int unsigned N_PE       = PEA_N_PE,
  parameter int unsigned DATA_W     = PEA_DATA_W,
  parameter int unsigned ADDR_W     = PEA_ADDR_W,
  parameter int unsigned N_ENG      = PEA_N_ENG,
  parameter int unsigned DENSE_LANE = N_BUF - 1,
  parameter int unsigned DRAIN_CYC  = PEA_DRAIN_CYC,
  parameter int unsigned ENG_W      = $clog2(N_ENG + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sel_req_valid,
  input  logic [ENG_W-1:0]              sel_req_eng,
  output logic                          sel_req_ready,
  input  route_e                        eng_route     [1:N_ENG],
  input  buf_ctrl_t                     eng_buf1_ctrl [1:N_ENG],
  input  buf_ctrl_t                     eng_buf2_ctrl [1:N_ENG],
  input  pea_ctrl_t                     eng_pea_ctrl  [1:N_ENG],
  input  logic [N_BUF-1:0][DATA_W-1:0]  buf1_rdata,
  input  logic [N_BUF-1:0][DATA_W-1:0]  buf2_rdata,
  input  logic [N_BUF-1:0][DATA_W-1:0]  pea_out,
  output buf_ctrl_t                     buf1_ctrl,
  output buf_ctrl_t                     buf2_ctrl,
  output logic [N_BUF-1:0][DATA_W-1:0]  buf1_wdata,
  output logic [N_BUF-1:0][DATA_W-1:0]  buf2_wdata,
  output logic                          buf_mode,
  output pea_ctrl_t                     pea_ctrl,
  output logic [N_BUF-1:0][DATA_W-1:0]  pea_in1,
  output logic [N_BUF-1:0][DATA_W-1:0]  pea_in2,
  output logic [ENG_W-1:0]              active_eng,
  output route_e                        route_q,
  output logic                          busy,
  output logic                          err_sticky
);

  localparam int unsigned CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  xbar_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ENG_W-1:0]  pending_q, pending_d;
  logic [ENG_W-1:0]  active_d;
  route_e            route_d;
  logic              err_d;

  logic              accept;
  logic              req_oor;
  logic [ENG_W-1:0]  req_code;

  route_e            cur_route, pend_route;
  buf_ctrl_t         cur_b1, cur_b2;
  pea_ctrl_t         cur_pea;

  logic [N_BUF-1:0][DATA_W-1:0] rt_in1, rt_in2, rt_wdata;

  assign sel_req_ready = (state_q != S_DRAIN);
  assign busy          = (state_q == S_DRAIN);
  assign accept        = sel_req_valid && sel_req_ready;
  assign req_oor       = 32'(sel_req_eng) > N_ENG;
  assign req_code      = req_oor ? ENG_W'(ENG_IDLE) : sel_req_eng;

  // Compare-select instead of direct indexing keeps idle/out-of-range codes off the arrays.
  always_comb begin
    cur_route  = ROUTE_IDLE;
    pend_route = ROUTE_IDLE;
    cur_b1     = BUF_CTRL_IDLE;
    cur_b2     = BUF_CTRL_IDLE;
    cur_pea    = PEA_CTRL_IDLE;
    for (int unsigned e = 1; e <= N_ENG; e++) begin
      if (active_eng == ENG_W'(e)) begin
        cur_route = eng_route[e];
        cur_b1    = eng_buf1_ctrl[e];
        cur_b2    = eng_buf2_ctrl[e];
        cur_pea   = eng_pea_ctrl[e];
      end
      if (pending_q == ENG_W'(e)) pend_route = eng_route[e];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    active_d  = active_eng;
    route_d   = route_q;
    err_d     = err_sticky || (accept && req_oor);
    unique case (state_q)
      S_IDLE: begin
        if (accept && (req_oor || req_code != ENG_W'(ENG_IDLE))) begin
          state_d   = S_DRAIN;
          cnt_d     = CNT_W'(DRAIN_CYC - 1);
          pending_d = req_code;
        end
      end
      S_ACTIVE: begin
        if (accept && req_code != active_eng) begin
          state_d   = S_DRAIN;
          cnt_d     = CNT_W'(DRAIN_CYC - 1);
          pending_d = req_code;
        end else if (cur_route != route_q) begin
          state_d   = S_DRAIN;
          cnt_d     = CNT_W'(DRAIN_CYC - 1);
          pending_d = active_eng;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          active_d = pending_q;
          route_d  = pend_route;
          state_d  = (pending_q == ENG_W'(ENG_IDLE)) ? S_IDLE : S_ACTIVE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pending_q  <= '0;
      active_eng <= '0;
      route_q    <= ROUTE_IDLE;
      err_sticky <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      active_eng <= active_d;
      route_q    <= route_d;
      err_sticky <= err_d;
    end
  end

  buffer_pea_route #(
    .N_BUF      (N_BUF),
    .DATA_W     (DATA_W),
    .DENSE_LANE (DENSE_LANE)
  ) u_route (
    .route  (route_q),
    .rdata1 (buf1_rdata),
    .rdata2 (buf2_rdata),
    .pout   (pea_out),
    .in1    (rt_in1),
    .in2    (rt_in2),
    .wdata  (rt_wdata)
  );

  function automatic buf_ctrl_t drain_buf(input buf_ctrl_t c);
    buf_ctrl_t d;
    d        = c;
    d.r_en   = {N_BUF{1'b0}};
    d.w_en   = {N_BUF{1'b0}};
    d.r_addr = c.r_addr[ADDR_W-1:0];
    d.w_addr = c.w_addr[ADDR_W-1:0];
    return d;
  endfunction

  function automatic pea_ctrl_t drain_pea(input pea_ctrl_t c);
    pea_ctrl_t d;
    d            = c;
    d.mac_enable = {N_PE{1'b0}};
    d.shifting_h = 1'b0;
    d.shifting_v = 1'b0;
    return d;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf1_ctrl  <= BUF_CTRL_IDLE;
      buf2_ctrl  <= BUF_CTRL_IDLE;
      pea_ctrl   <= PEA_CTRL_IDLE;
      buf_mode   <= 1'b0;
      pea_in1    <= '0;
      pea_in2    <= '0;
      buf1_wdata <= '0;
      buf2_wdata <= '0;
    end else begin
      buf_mode <= (active_eng != ENG_W'(ENG_IDLE));
      unique case (state_q)
        S_ACTIVE: begin
          buf1_ctrl <= cur_b1;
          buf2_ctrl <= cur_b2;
          pea_ctrl  <= cur_pea;
        end
        S_DRAIN: begin
          buf1_ctrl <= drain_buf(buf1_ctrl);
          buf2_ctrl <= drain_buf(buf2_ctrl);
          pea_ctrl  <= drain_pea(pea_ctrl);
        end
        default: begin
          buf1_ctrl <= BUF_CTRL_IDLE;
          buf2_ctrl <= BUF_CTRL_IDLE;
          pea_ctrl  <= PEA_CTRL_IDLE;
        end
      endcase
      if (state_q == S_IDLE) begin
        pea_in1    <= '0;
        pea_in2    <= '0;
        buf1_wdata <= '0;
        buf2_wdata <= '0;
      end else begin
        pea_in1    <= rt_in1;
        pea_in2    <= rt_in2;
        buf1_wdata <= rt_wdata;
        buf2_wdata <= rt_wdata;
      end
    end
  end

endmodule

// File: tb/tb_buffer_pea_xbar.sv
// Scoreboard bench for buffer_pea_xbar: engine switching, drain window, routes, errors, async reset.
module tb_buffer_pea_xbar;
  import pea_pkg::*;

  localparam int unsigned N_BUF     = 33;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned N_ENG     = 3;
  localparam int unsigned ENG_W     = 3;
  localparam int unsigned DENSE     = N_BUF - 1;
  localparam int unsigned DRAIN_CYC = 4;

  typedef logic [N_BUF-1:0][DATA_W-1:0] lanes_t;
  typedef struct {
    lanes_t in1;
    lanes_t in2;
    lanes_t wd;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sel_req_valid;
  logic [ENG_W-1:0] sel_req_eng;
  logic             sel_req_ready;
  route_e           eng_route     [1:N_ENG];
  buf_ctrl_t        eng_buf1_ctrl [1:N_ENG];
  buf_ctrl_t        eng_buf2_ctrl [1:N_ENG];
  pea_ctrl_t        eng_pea_ctrl  [1:N_ENG];
  lanes_t           buf1_rdata, buf2_rdata, pea_out;
  buf_ctrl_t        buf1_ctrl, buf2_ctrl;
  lanes_t           buf1_wdata, buf2_wdata, pea_in1, pea_in2;
  logic             buf_mode;
  pea_ctrl_t        pea_ctrl;
  logic [ENG_W-1:0] active_eng;
  route_e           route_q;
  logic             busy;
  logic             err_sticky;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  buffer_pea_xbar #(
    .N_BUF     (N_BUF),
    .DATA_W    (DATA_W),
    .N_ENG     (N_ENG),
    .DRAIN_CYC (DRAIN_CYC),
    .ENG_W     (ENG_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sel_req_valid (sel_req_valid),
    .sel_req_eng   (sel_req_eng),
    .sel_req_ready (sel_req_ready),
    .eng_route     (eng_route),
    .eng_buf1_ctrl (eng_buf1_ctrl),
    .eng_buf2_ctrl (eng_buf2_ctrl),
    .eng_pea_ctrl  (eng_pea_ctrl),
    .buf1_rdata    (buf1_rdata),
    .buf2_rdata    (buf2_rdata),
    .pea_out       (pea_out),
    .buf1_ctrl     (buf1_ctrl),
    .buf2_ctrl     (buf2_ctrl),
    .buf1_wdata    (buf1_wdata),
    .buf2_wdata    (buf2_wdata),
    .buf_mode      (buf_mode),
    .pea_ctrl      (pea_ctrl),
    .pea_in1       (pea_in1),
    .pea_in2       (pea_in2),
    .active_eng    (active_eng),
    .route_q       (route_q),
    .busy          (busy),
    .err_sticky    (err_sticky)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input route_e r, input lanes_t a, input lanes_t b, input lanes_t o);
    exp_t x;
    for (int i = 0; i < N_BUF; i++) begin
      case (r)
        AYBZ:    begin x.in1[i] = a[i]; x.in2[i] = b[i];     x.wd[i] = o[i];     end
        AZBY:    begin x.in1[i] = b[i]; x.in2[i] = a[i];     x.wd[i] = o[i];     end
        AYaZ:    begin x.in1[i] = a[i]; x.in2[i] = a[DENSE]; x.wd[i] = o[DENSE]; end
        default: begin x.in1[i] = b[i]; x.in2[i] = b[DENSE]; x.wd[i] = o[DENSE]; end
      endcase
    end
    return x;
  endfunction

  task automatic data_cycle(input route_e r, input bit dense_ab);
    exp_t e;
    for (int i = 0; i < N_BUF; i++) begin
      buf1_rdata[i] = 16'($urandom);
      buf2_rdata[i] = 16'($urandom);
      pea_out[i]    = 16'($urandom);
    end
    if (dense_ab) buf1_rdata[DENSE] = 16'h00AB;
    sb.push_back(model(r, buf1_rdata, buf2_rdata, pea_out));
    tick();
    e = sb.pop_front();
    for (int i = 0; i < N_BUF; i++) begin
      check($sformatf("pea_in1[%0d]", i), pea_in1[i], e.in1[i]);
      check($sformatf("pea_in2[%0d]", i), pea_in2[i], e.in2[i]);
      check($sformatf("buf1_wdata[%0d]", i), buf1_wdata[i], e.wd[i]);
      check($sformatf("buf2_wdata[%0d]", i), buf2_wdata[i], e.wd[i]);
    end
  endtask

  // Call right after the accepting edge; returns after the first sample with busy low.
  task automatic run_drain(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 20) begin
      check({tag, "_ready"}, sel_req_ready, 1'b0);
      tick();
      n++;
      check({tag, "_w_en"}, {buf1_ctrl.w_en, buf2_ctrl.w_en, buf1_ctrl.r_en}, '0);
      check({tag, "_mac"}, {pea_ctrl.mac_enable, pea_ctrl.shifting_h, pea_ctrl.shifting_v}, '0);
    end
    check({tag, "_len"}, n, DRAIN_CYC);
  endtask

  task automatic request(input logic [ENG_W-1:0] code);
    sel_req_valid = 1'b1;
    sel_req_eng   = code;
    check($sformatf("req%0d_ready", code), sel_req_ready, 1'b1);
    tick();
    sel_req_valid = 1'b0;
    sel_req_eng   = '0;
  endtask

  initial begin
    rst_n         = 1'b0;
    sel_req_valid = 1'b0;
    sel_req_eng   = '0;
    buf1_rdata    = '0;
    buf2_rdata    = '0;
    pea_out       = '0;
    for (int e = 1; e <= N_ENG; e++) begin
      eng_route[e]                       = AYBZ;
      eng_buf1_ctrl[e].r_en              = 33'({$urandom, $urandom}) | 33'h1;
      eng_buf1_ctrl[e].w_en              = 33'({$urandom, $urandom}) | 33'h1;
      eng_buf1_ctrl[e].r_addr            = 10'(100 * e + 1);
      eng_buf1_ctrl[e].w_addr            = 10'(200 + e);
      eng_buf2_ctrl[e].r_en              = 33'({$urandom, $urandom}) | 33'h2;
      eng_buf2_ctrl[e].w_en              = 33'({$urandom, $urandom}) | 33'h2;
      eng_buf2_ctrl[e].r_addr            = 10'(300 + e);
      eng_buf2_ctrl[e].w_addr            = 10'(400 + e);
      eng_pea_ctrl[e].mac_enable         = $urandom | 32'h1;
      eng_pea_ctrl[e].shifting_h         = 1'b1;
      eng_pea_ctrl[e].shifting_v         = e[0];
      eng_pea_ctrl[e].dense_adder_reset  = 1'b0;
    end
    eng_route[2] = AYaZ;
    eng_route[3] = BYbZ;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_busy", busy, 1'b0);
    check("rst_active", active_eng, '0);
    check("rst_route", route_q, AYBZ);
    check("rst_err", err_sticky, 1'b0);
    check("rst_mode", buf_mode, 1'b0);
    check("rst_pea_ctrl", pea_ctrl, PEA_CTRL_IDLE);
    check("rst_buf1_ctrl", buf1_ctrl, '0);
    check("rst_pea_in1", pea_in1[0], '0);

    request(3'd0);
    check("noop0_busy", busy, 1'b0);

    request(3'd1);
    run_drain("eng1");
    check("eng1_active", active_eng, 3'd1);
    check("eng1_route", route_q, AYBZ);
    data_cycle(AYBZ, 1'b0);
    check("eng1_b1ctrl", buf1_ctrl, eng_buf1_ctrl[1]);
    check("eng1_pea", pea_ctrl, eng_pea_ctrl[1]);
    check("eng1_mode", buf_mode, 1'b1);
    data_cycle(AYBZ, 1'b0);

    eng_route[1] = AZBY;
    tick();
    run_drain("reroute");
    check("reroute_raddr_hold", buf1_ctrl.r_addr, eng_buf1_ctrl[1].r_addr);
    check("reroute_route", route_q, AZBY);
    check("reroute_active", active_eng, 3'd1);
    data_cycle(AZBY, 1'b0);
    data_cycle(AZBY, 1'b0);

    request(3'd2);
    run_drain("eng2");
    check("eng2_active", active_eng, 3'd2);
    check("eng2_route", route_q, AYaZ);
    data_cycle(AYaZ, 1'b1);
    check("eng2_b2ctrl", buf2_ctrl, eng_buf2_ctrl[2]);
    check("eng2_dense_in2", pea_in2[0], 16'h00AB);
    data_cycle(AYaZ, 1'b1);

    request(3'd3);
    sel_req_valid = 1'b1;
    sel_req_eng   = 3'd1;
    run_drain("eng3_held");
    check("eng3_active", active_eng, 3'd3);
    check("held_ready", sel_req_ready, 1'b1);
    data_cycle(BYbZ, 1'b0);
    sel_req_valid = 1'b0;
    sel_req_eng   = '0;
    check("eng3_b1ctrl", buf1_ctrl, eng_buf1_ctrl[3]);
    check("held_accepted", busy, 1'b1);
    run_drain("held");
    check("held_active", active_eng, 3'd1);
    check("held_route", route_q, AZBY);
    data_cycle(AZBY, 1'b0);

    request(3'd7);
    check("oor_err", err_sticky, 1'b1);
    run_drain("oor");
    check("oor_active", active_eng, '0);
    check("oor_route", route_q, AYBZ);
    tick();
    check("oor_mode", buf_mode, 1'b0);
    check("oor_pea_ctrl", pea_ctrl, PEA_CTRL_IDLE);
    check("oor_buf1_ctrl", buf1_ctrl, '0);
    check("oor_data0", pea_in1[0], '0);
    check("oor_dataD", buf2_wdata[DENSE], '0);

    request(3'd2);
    tick();
    check("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_active", active_eng, '0);
    check("arst_route", route_q, AYBZ);
    check("arst_err", err_sticky, 1'b0);
    check("arst_ready", sel_req_ready, 1'b1);
    check("arst_pea_ctrl", pea_ctrl, PEA_CTRL_IDLE);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("post_active", active_eng, '0);
    check("post_busy", busy, 1'b0);
    check("post_mode", buf_mode, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
